// File: rtl/aes_decrypt_core.sv
// rtl/aes_decrypt_core.sv - iterative AES-128 inverse cipher, one round per clock
module aes_decrypt_core #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] cipher_text,
  input  logic [127:0] round_key,
  output logic         key_load,
  output logic         key_next,
  output logic         ready,
  output logic         done,
  output logic [127:0] plain_text
);

  typedef enum logic [1:0] {IDLE, INIT, ROUND, FINAL} fsm_t;

  fsm_t         fsm;
  logic [3:0]   rnd;
  logic [127:0] st;
  logic [127:0] ct_reg;
  logic [127:0] inv_core;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // Inverse affine transform followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] a;
    a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(a);
  endfunction

  // Byte i sits at [127-8i -: 8]; byte index = 4*column + row.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  assign ready    = (fsm == IDLE);
  assign key_load = start & ready;
  assign key_next = (fsm == INIT) || (fsm == ROUND);

  // InvShiftRows + InvSubBytes shared by the middle rounds and the final round
  always_comb begin
    inv_core = inv_sub_bytes(inv_shift_rows(st));
  end

  // Round sequencer and datapath; done and plain_text are registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm        <= IDLE;
      rnd        <= 4'd0;
      st         <= '0;
      ct_reg     <= '0;
      plain_text <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            ct_reg <= cipher_text;
            rnd    <= 4'(NR - 1);
            fsm    <= INIT;
          end
        end
        INIT: begin
          st  <= ct_reg ^ round_key;
          fsm <= ROUND;
        end
        ROUND: begin
          st  <= inv_mix_columns(inv_core ^ round_key);
          rnd <= rnd - 4'd1;
          if (rnd == 4'd1) fsm <= FINAL;
        end
        FINAL: begin
          plain_text <= inv_core ^ round_key;
          done       <= 1'b1;
          fsm        <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// tb/tb_aes_decrypt_core.sv - self-checking bench for aes_decrypt_core
module tb_aes_decrypt_core;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] cipher_text;
  logic [127:0] round_key;
  logic         key_load;
  logic         key_next;
  logic         ready;
  logic         done;
  logic [127:0] plain_text;

  aes_decrypt_core #(.NR(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cipher_text (cipher_text),
    .round_key   (round_key),
    .key_load    (key_load),
    .key_next    (key_next),
    .ready       (ready),
    .done        (done),
    .plain_text  (plain_text)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  logic [127:0] rk [0:10];
  logic [7:0]   sbox_t [0:255];
  logic [3:0]   kidx;
  int           n_load = 0;
  int           n_next = 0;

  // Key source: K10 after key_load, step down on key_next
  always @(posedge clk) begin
    if (reset) kidx <= 4'd0;
    else if (key_load) kidx <= 4'd10;
    else if (key_next) kidx <= kidx - 4'd1;
    if (key_load) n_load <= n_load + 1;
    if (key_next) n_next <= n_next + 1;
  end

  assign round_key = (kidx <= 4'd10) ? rk[kidx] : '0;

  int           n_vec = 0;
  int           n_bad = 0;
  int           cyc = 0;
  int           done_cyc = 0;
  int           n_done = 0;
  bit           mon_en = 0;
  logic         prev_done = 1'b0;
  logic [127:0] last_pt = '0;
  logic [127:0] exp_q [$];

  function automatic logic [7:0] b_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] b_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = b_xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] b_inv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    for (int c = 1; c < 256; c++)
      if (b_mul(x, 8'(c)) == 8'h01) r = 8'(c);
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] a;
    for (int x = 0; x < 256; x++) begin
      a = b_inv(8'(x));
      sbox_t[x] = a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = b_xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [127:0] s;
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sbox_t[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          o[127-8*(4*c+q) -: 8] = s[127-8*(4*((c+q)%4)+q) -: 8];
      s = o;
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
          o[127-32*c -: 8] = b_mul(a0, 8'h02) ^ b_mul(a1, 8'h03) ^ a2 ^ a3;
          o[119-32*c -: 8] = a0 ^ b_mul(a1, 8'h02) ^ b_mul(a2, 8'h03) ^ a3;
          o[111-32*c -: 8] = a0 ^ a1 ^ b_mul(a2, 8'h02) ^ b_mul(a3, 8'h03);
          o[103-32*c -: 8] = b_mul(a0, 8'h03) ^ a1 ^ a2 ^ b_mul(a3, 8'h02);
        end
        s = o;
      end
      s = s ^ rk[r];
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample at negedge, run the scoreboard, then the caller drives inputs.
  task automatic tick();
    logic [127:0] e;
    @(negedge clk);
    cyc++;
    if (mon_en) begin
      if (done) begin
        check("done_width", prev_done, 1'b0);
        if (exp_q.size() == 0) check("unexpected_done", 1'b1, 1'b0);
        else begin
          e = exp_q.pop_front();
          check("plain_text", plain_text, e);
        end
        last_pt  = plain_text;
        done_cyc = cyc;
        n_done++;
      end else if (reset) begin
        check("reset_plain_text", plain_text, '0);
        last_pt = '0;
      end else begin
        check("pt_hold", plain_text, last_pt);
      end
      prev_done = done;
    end
  endtask

  task automatic run_block(input logic [127:0] key, input logic [127:0] ct,
                           input logic [127:0] pt, input bit chk_gap);
    int k, w, ln, nn, pd;
    expand_key(key);
    w = 0;
    while (!ready && w < 50) begin tick(); w++; end
    if (!ready) check("ready_wait", ready, 1'b1);
    ln = n_load;
    nn = n_next;
    pd = done_cyc;
    cipher_text = ct;
    start = 1'b1;
    exp_q.push_back(pt);
    tick();
    start = 1'b0;
    cipher_text = {$urandom, $urandom, $urandom, $urandom};
    k = 1;
    while (!done && k < 30) begin tick(); k++; end
    if (!done) exp_q.delete();
    check("latency", 128'(k), 128'(12));
    check("key_next_count", 128'(n_next - nn), 128'(10));
    check("key_load_count", 128'(n_load - ln), 128'(1));
    if (chk_gap) check("done_gap", 128'(done_cyc - pd), 128'(12));
  endtask

  initial begin
    vec_t vecs [0:2];
    logic [127:0] key, pt, ct;
    int k, nd;

    vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                pt:  128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                ct:  128'h3925841d02dc09fbdc118597196a0b32,
                pt:  128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{key: 128'h0,
                ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                pt:  128'h0};

    build_sbox();
    for (int r = 0; r < 11; r++) rk[r] = '0;
    reset = 1'b1;
    start = 1'b0;
    cipher_text = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_ready", ready, 1'b1);
    check("reset_done", done, 1'b0);
    check("reset_pt", plain_text, '0);
    check("reset_key_next", key_next, 1'b0);
    check("reset_key_load", key_load, 1'b0);
    mon_en = 1;
    last_pt = '0;

    // Known-answer vectors, back to back; C.1 repeated straight after the zero-key block
    for (int i = 0; i < 3; i++) run_block(vecs[i].key, vecs[i].ct, vecs[i].pt, i > 0);
    run_block(vecs[0].key, vecs[0].ct, vecs[0].pt, 1'b1);

    // start held then toggled with other ciphertext while busy
    repeat (2) tick();
    expand_key(vecs[0].key);
    nd = n_done;
    k = n_load;
    cipher_text = vecs[0].ct;
    start = 1'b1;
    exp_q.push_back(vecs[0].pt);
    tick();
    for (int c = 1; c < 30 && !done; c++) begin
      start = (c < 6) ? 1'b1 : 1'(c % 2);
      cipher_text = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    start = 1'b0;
    check("busy_key_load", 128'(n_load - k), 128'(1));
    repeat (2) tick();
    check("busy_idle_after", ready, 1'b1);
    check("busy_one_done", 128'(n_done - nd), 128'(1));

    // Reset in cycle 6 of an operation
    expand_key(vecs[1].key);
    nd = n_done;
    cipher_text = vecs[1].ct;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    reset = 1'b1;
    tick();
    check("midrst_ready", ready, 1'b1);
    check("midrst_done", done, 1'b0);
    check("midrst_key_next", key_next, 1'b0);
    reset = 1'b0;
    repeat (15) tick();
    check("midrst_no_done", 128'(n_done - nd), 128'(0));
    run_block(vecs[1].key, vecs[1].ct, vecs[1].pt, 1'b0);

    // Loopback against the bench's forward cipher
    for (int n = 0; n < 1000; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expand_key(key);
      ct = aes_enc(pt);
      run_block(key, ct, pt, n > 0);
    end

    repeat (3) tick();
    check("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
